prog_readback: RTL and testbench
================================

PROG_READBACK -- requirements
Module: prog_readback

Interface
REQ-001 SHALL have parameters: NUM_BITS, 104, programmed-word width; RB_CMD, 8'hA5, readback command byte.
REQ-002 SHALL have reset: reset, asynchronous, active-low; clock SCLK.
REQ-003 SHALL have ports:
- SCLK  input  1  serial clock; all state on rising edge.
- reset  input  1  async active-low reset.
- CS  input  1  chip select, active-low frame.
- SDI  input  1  command bits from host, LSB first.
- prog_data  input  NUM_BITS  current programmed word, stable while CS low.
- SDO  output  1  readback serial data, registered.
- SDO_OE  output  1  SDO pad enable.
- rb_busy  output  1  high in SEND or CRC state.

Function
REQ-004 SHALL implement states IDLE, CMD, SEND, CRC, DONE as an FSM clocked on the SCLK rising edge.
REQ-005 SHALL force IDLE, clear the 7-bit bit counter, and set SDO=0 on every SCLK rising edge sampling CS=1; a new frame requires at least one such edge.
REQ-006 SHALL, in IDLE with CS=0, shift SDI into an 8-bit command register (LSB first), set counter=1, and enter CMD.
REQ-007 SHALL, in CMD, shift SDI each edge; on the 8th CS-low edge, compare the assembled byte with RB_CMD.
- match: snapshot prog_data into the tx shift register, SDO<=prog_data[0], counter<=0, enter SEND.
- mismatch: enter DONE.
REQ-008 SHALL, in SEND, shift right one bit per edge with SDO<=next bit; host samples bit k at CS-low edge 9+k (k=0..NUM_BITS-1), one edge of latency after each SDO update.
REQ-009 SHALL, when the counter reaches NUM_BITS-1 in SEND, enter CRC if READBACK_CRC_EN is defined, else DONE with SDO<=0.
REQ-010 SHALL hold DONE with SDO=0, ignoring SDI, until CS=1 is sampled.
REQ-011 SHALL drive SDO_OE = !CS AND (state is SEND or CRC), combinationally, so the pad releases immediately on CS rise.
REQ-012 SHALL ignore prog_data changes after the snapshot edge.
REQ-013 SHALL abort cleanly on CS rise mid-frame: the next sampled edge yields IDLE, and no partial state carries over.

Reset
REQ-014 SHALL, on reset low, asynchronously set state=IDLE, counter=0, command register=0, tx register=0, CRC register=0, SDO=0, rb_busy=0; SDO_OE=0 follows combinationally.
REQ-015 SHALL behave after reset release exactly as after a CS-high edge.

Configuration
REQ-016 SHALL compile the CRC trailer only when READBACK_CRC_EN is defined.
- Defined: CRC-8, poly 0x07, init 0x00, fed with each transmitted data bit in send order; 8 CRC bits sent LSB first at edges NUM_BITS+9..NUM_BITS+16, then DONE.
- Undefined: no CRC state or logic; the frame ends after the data bits.

Structure
REQ-017 SHALL take NUM_BITS default, RB_CMD default, CRC_POLY=8'h07, and the state enum typedef from package prog_pkg.
REQ-018 SHALL place the CRC in sub-module crc8_serial (clk, reset, clr, en, din, crc[7:0]), instantiated only under READBACK_CRC_EN.

Verification
REQ-019 Bench SHALL cover:
- Edge with CS=1, CS low, SDI=0xA5 LSB first, prog_data=104'h1 -> SDO=1 sampled at edge 9, 0 at edges 10..112, SDO_OE high edges 8..112.
- Command 0x5A -> state DONE, SDO_OE=0, SDO=0 for the rest of the frame.
- CS raised after edge 50 of a valid readback, then a new frame with CS=1 edge -> SDO_OE drops at once, second frame returns full correct word.
- prog_data changed at edge 20 -> output matches the value snapshotted at edge 8.
- READBACK_CRC_EN, prog_data=0 -> 104 zeros then CRC 0x00; random prog_data -> CRC matches golden model, DONE after edge 120.
- Reset asserted at edge 60 -> all outputs 0 immediately; next valid frame correct.

Source files
------------

// File: rtl/prog_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_pkg
// Description : Shared constants, FSM state type and CRC-8 step function for
//               the programmed-word readback block. The CRC state exists only
//               when READBACK_CRC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_pkg;

    localparam int         DEF_NUM_BITS = 104;
    localparam logic [7:0] DEF_RB_CMD   = 8'hA5;
    localparam logic [7:0] CRC_POLY     = 8'h07;

`ifdef READBACK_CRC_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_SEND = 3'd2,
        ST_CRC  = 3'd3,
        ST_DONE = 3'd4
    } rb_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_SEND = 3'd2,
        ST_DONE = 3'd4
    } rb_state_t;
`endif

    // One bit of an MSB-first serial CRC-8 (shift left, feedback into the poly).
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic w_fb;
        w_fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc8_serial.sv
`default_nettype none
// ============================================================================
// Module      : crc8_serial
// Description : Bit-serial CRC-8 accumulator with synchronous clear and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module crc8_serial
    import prog_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_readback.sv
`default_nettype none
// ============================================================================
// Module      : prog_readback
// Description : Serial readback of the programmed word. A command byte on SDI
//               selects readback; the snapshotted word is shifted out on SDO
//               LSB first. Define READBACK_CRC_EN to append a CRC-8 trailer.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_readback
    import prog_pkg::*;
#(
    parameter int         NUM_BITS = DEF_NUM_BITS,
    parameter logic [7:0] RB_CMD   = DEF_RB_CMD
) (
    input  logic                SCLK,
    input  logic                reset,
    input  logic                CS,
    input  logic                SDI,
    input  logic [NUM_BITS-1:0] prog_data,
    output logic                SDO,
    output logic                SDO_OE,
    output logic                rb_busy
);

    localparam logic [6:0] c_last_bit = 7'(NUM_BITS - 1);
    localparam logic [6:0] c_last_cmd = 7'd7;

    rb_state_t           r_state;
    rb_state_t           w_state_nxt;
    logic [6:0]          r_cnt;
    logic [6:0]          w_cnt_nxt;
    logic [7:0]          r_cmd;
    logic [7:0]          w_cmd_nxt;
    logic [7:0]          w_cmd_shift;
    logic [NUM_BITS-1:0] r_tx;
    logic [NUM_BITS-1:0] w_tx_nxt;
    logic                r_sdo;
    logic                w_sdo_nxt;
    logic                w_busy;

`ifdef READBACK_CRC_EN
    localparam logic [6:0] c_last_crc = 7'd7;

    logic       w_crc_clr;
    logic       w_crc_en;
    logic       w_crc_din;
    logic [7:0] w_crc;

    crc8_serial u_crc8_serial (
        .clk   (SCLK),
        .reset (reset),
        .clr   (w_crc_clr),
        .en    (w_crc_en),
        .din   (w_crc_din),
        .crc   (w_crc)
    );

    assign w_crc_clr = CS || (r_state == ST_IDLE);
    assign w_busy    = (r_state == ST_SEND) || (r_state == ST_CRC);
`else
    assign w_busy    = (r_state == ST_SEND);
`endif

    assign w_cmd_shift = {SDI, r_cmd[7:1]};

    // State register plus datapath registers; all cleared by the async reset.
    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 7'd0;
            r_cmd   <= 8'h00;
            r_tx    <= '0;
            r_sdo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cmd   <= w_cmd_nxt;
            r_tx    <= w_tx_nxt;
            r_sdo   <= w_sdo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cmd_nxt   = r_cmd;
        w_tx_nxt    = r_tx;
        w_sdo_nxt   = 1'b0;
`ifdef READBACK_CRC_EN
        w_crc_en    = 1'b0;
        w_crc_din   = 1'b0;
`endif

        if (CS) begin
            // Deselected edge: drop every trace of the previous frame.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 7'd0;
            w_cmd_nxt   = 8'h00;
            w_tx_nxt    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cmd_nxt   = w_cmd_shift;
                    w_cnt_nxt   = 7'd1;
                    w_state_nxt = ST_CMD;
                end

                ST_CMD: begin
                    w_cmd_nxt = w_cmd_shift;
                    w_cnt_nxt = r_cnt + 7'd1;
                    if (r_cnt == c_last_cmd) begin
                        if (w_cmd_shift == RB_CMD) begin
                            // Snapshot edge: bit 0 goes out now, the rest is held here.
                            w_tx_nxt    = prog_data >> 1;
                            w_sdo_nxt   = prog_data[0];
                            w_cnt_nxt   = 7'd0;
                            w_state_nxt = ST_SEND;
`ifdef READBACK_CRC_EN
                            w_crc_en    = 1'b1;
                            w_crc_din   = prog_data[0];
`endif
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end

                ST_SEND: begin
                    if (r_cnt == c_last_bit) begin
`ifdef READBACK_CRC_EN
                        w_tx_nxt    = {{(NUM_BITS-7){1'b0}}, w_crc[7:1]};
                        w_sdo_nxt   = w_crc[0];
                        w_cnt_nxt   = 7'd0;
                        w_state_nxt = ST_CRC;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end else begin
                        w_sdo_nxt = r_tx[0];
                        w_tx_nxt  = r_tx >> 1;
                        w_cnt_nxt = r_cnt + 7'd1;
`ifdef READBACK_CRC_EN
                        w_crc_en  = 1'b1;
                        w_crc_din = r_tx[0];
`endif
                    end
                end

`ifdef READBACK_CRC_EN
                ST_CRC: begin
                    if (r_cnt == c_last_crc) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_sdo_nxt = r_tx[0];
                        w_tx_nxt  = r_tx >> 1;
                        w_cnt_nxt = r_cnt + 7'd1;
                    end
                end
`endif

                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 7'd0;
                end
            endcase
        end
    end

    assign SDO     = r_sdo;
    assign rb_busy = w_busy;
    // Pad enable is gated by CS directly so it releases without waiting for an edge.
    assign SDO_OE  = !CS && w_busy;

endmodule
`default_nettype wire

// File: tb/tb_prog_readback.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_readback
// Description : Randomized scoreboard bench for prog_readback; expected SDO
//               bits are queued per frame and popped while SDO_OE is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_readback;

    localparam int         N      = 104;
    localparam logic [7:0] RB     = 8'hA5;
`ifdef READBACK_CRC_EN
    localparam int         CRCB   = 8;
`else
    localparam int         CRCB   = 0;
`endif

    logic         SCLK;
    logic         reset;
    logic         CS;
    logic         SDI;
    logic [N-1:0] prog_data;
    logic         SDO;
    logic         SDO_OE;
    logic         rb_busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];

    prog_readback #(
        .NUM_BITS (N),
        .RB_CMD   (RB)
    ) dut (
        .SCLK      (SCLK),
        .reset     (reset),
        .CS        (CS),
        .SDI       (SDI),
        .prog_data (prog_data),
        .SDO       (SDO),
        .SDO_OE    (SDO_OE),
        .rb_busy   (rb_busy)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every bit presented while the pad is enabled must match the queue head.
    always @(negedge SCLK) begin
        if (SDO_OE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sdo", 32'(exp_q.size()), 32'd1);
            end else begin
                check("sdo_bit", 32'(SDO), 32'(exp_q.pop_front()));
            end
        end
    end

`ifdef READBACK_CRC_EN
    // CRC as the remainder of the polynomial long division of msg(x)*x^8 by x^8+x^2+x+1.
    function automatic logic [7:0] crc_model(input logic [N-1:0] d);
        bit         m [N+8];
        logic [8:0] poly9;
        logic [7:0] r;
        poly9 = 9'h107;
        for (int i = 0; i < N + 8; i++) m[i] = (i < N) ? d[i] : 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                for (int j = 0; j <= 8; j++) m[i+j] = m[i+j] ^ poly9[8-j];
            end
        end
        for (int j = 0; j < 8; j++) r[7-j] = m[N+j];
        return r;
    endfunction
`endif

    task automatic edge_drv(input logic cs, input logic sdi);
        CS  = cs;
        SDI = sdi;
        @(posedge SCLK);
        #1;
    endtask

    function automatic logic [N-1:0] rand_word();
        logic [127:0] tmp;
        tmp = {$urandom, $urandom, $urandom, $urandom};
        return tmp[N-1:0];
    endfunction

    // One frame: CS-high edge, command byte, then readback edges. A nonzero
    // abort_e / rst_e stops the frame right after that CS-low edge.
    task automatic frame(input logic [N-1:0] data, input logic [7:0] cmd,
                         input int abort_e, input int chg_e, input int rst_e);
        bit         match;
        int         nbits;
        int         vis;
        int         total;
        int         stop_e;
        logic       sdi;
        logic [7:0] crc;
        logic [31:0] oe_after_data;

        crc = 8'h00;
`ifdef READBACK_CRC_EN
        crc = crc_model(data);
        oe_after_data = 32'd1;
`else
        oe_after_data = 32'd0;
`endif
        edge_drv(1'b1, 1'b0);
        prog_data = data;
        match  = (cmd == RB);
        nbits  = match ? N + CRCB : 0;
        stop_e = (abort_e > 0) ? abort_e : rst_e;
        vis    = nbits;
        if (stop_e > 0) begin
            vis = stop_e - 8;
            if (vis < 0) vis = 0;
            if (vis > nbits) vis = nbits;
        end
        for (int k = 0; k < vis; k++) exp_q.push_back((k < N) ? data[k] : crc[k-N]);
        total = match ? N + 8 + CRCB + 2 : 20;

        for (int e = 1; e <= total; e++) begin
            sdi = (e <= 8) ? cmd[e-1] : 1'($urandom);
            edge_drv(1'b0, sdi);
            if (e == 7) check("oe_during_cmd", 32'(SDO_OE), 32'd0);
            if (match) begin
                if (e == 8)     check("oe_busy_at_snapshot", 32'({SDO_OE, rb_busy}), 32'd3);
                if (e == N + 7) check("oe_last_data", 32'(SDO_OE), 32'd1);
                if (e == N + 8) check("oe_after_data", 32'(SDO_OE), oe_after_data);
`ifdef READBACK_CRC_EN
                if (e == N + 16) check("done_after_crc", 32'({SDO_OE, rb_busy, SDO}), 32'd0);
`endif
            end else if (e >= 8) begin
                check("mismatch_quiet", 32'({SDO_OE, rb_busy, SDO}), 32'd0);
            end
            if (e == chg_e) prog_data = ~data;
            if (e == abort_e) begin
                CS = 1'b1;
                #1;
                check("oe_abort_release", 32'(SDO_OE), 32'd0);
                break;
            end
            if (e == rst_e) begin
                reset = 1'b0;
                #1;
                check("async_reset_outputs", 32'({SDO, SDO_OE, rb_busy}), 32'd0);
                break;
            end
        end

        edge_drv(1'b1, 1'b0);
        reset = 1'b1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("idle_after_frame", 32'({SDO, SDO_OE, rb_busy}), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [N-1:0] d;
        logic [7:0]   c;

        CS        = 1'b1;
        SDI       = 1'b0;
        prog_data = '0;
        reset     = 1'b0;
        #2;
        check("reset_outputs", 32'({SDO, SDO_OE, rb_busy}), 32'd0);
        edge_drv(1'b1, 1'b0);
        edge_drv(1'b1, 1'b0);
        reset = 1'b1;

        frame({{(N-1){1'b0}}, 1'b1}, RB, 0, 0, 0);
        frame(rand_word(), 8'h5A, 0, 0, 0);
        d = rand_word();
        frame(d, RB, 50, 0, 0);
        frame(d, RB, 0, 0, 0);
        frame(rand_word(), RB, 0, 20, 0);
        frame('0, RB, 0, 0, 0);
        frame(rand_word(), RB, 0, 0, 60);
        frame(rand_word(), RB, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            c = 8'($urandom);
            if (c == RB || ($urandom % 3) != 0) c = (c == RB && ($urandom % 2) == 0) ? 8'h3C : RB;
            frame(rand_word(), c, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
